// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the 8-digit common-anode 7-segment display controller.
//   SEG_OFF / AN_OFF  : all-dark segment and anode patterns (active-low outputs)
//   SEG_TABLE         : hex digit to {g,f,e,d,c,b,a} active-low segment patterns
//   REFRESH_CNT_DEF   : default clk cycles per digit slot (1 kHz slot rate at 100 MHz)
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [7:0] AN_OFF  = 8'hFF;

    localparam int REFRESH_CNT_DEF = 100000;

    // Element 0 is the rightmost entry, so SEG_TABLE[n] is the pattern for digit value n.
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

endpackage

// File: rtl/seg7_display_ctrl_hex_to_seg7.sv
// hex_to_seg7: combinational 4-bit hex digit to active-low 7-segment decoder.
//   nib_i : hex digit value
//   seg_o : segments {g,f,e,d,c,b,a}, active-low
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/seg7_display_ctrl.sv
// seg7_display_ctrl: latches a 32-bit value and scans it onto an 8-digit multiplexed 7-segment display.
//   clk      : system clock, all state on rising edge
//   rst      : synchronous active-high reset (all digits dark, scan restarts at digit 0)
//   ld       : one-cycle load strobe for d_in
//   d_in     : value to show, nibble i on digit i (digit 0 rightmost)
//   digit_en : live per-digit enable, 0 forces that digit dark
//   blank_lz : live leading-zero suppression enable
//   an       : registered active-low anode selects
//   hex_out  : registered active-low segments {g,f,e,d,c,b,a}
module seg7_display_ctrl
    import seg7_pkg::*;
#(
    parameter int REFRESH_CNT = REFRESH_CNT_DEF,
    parameter int CNT_W       = 17
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ld,
    input  logic [31:0] d_in,
    input  logic [7:0]  digit_en,
    input  logic        blank_lz,
    output logic [7:0]  an,
    output logic [6:0]  hex_out
);

    logic [CNT_W-1:0] presc_q, presc_d;
    logic [2:0]       idx_q, idx_d;
    logic [31:0]      disp_q, disp_d;
    logic [7:0]       an_q, an_d;
    logic [6:0]       hex_q, hex_d;
    logic             tick;
    logic [3:0]       nib;
    logic [6:0]       seg;
    logic [7:0]       upper_zero;
    logic [7:0]       lz_blank;
    logic             dark;

    assign tick = presc_q == CNT_W'(REFRESH_CNT - 1);

    // upper_zero[i] is set when nibbles i..7 of the held value are all zero.
    assign upper_zero[7] = disp_q[31:28] == 4'h0;
    for (genvar g = 0; g < 7; g++) begin : g_uz
        assign upper_zero[g] = upper_zero[g+1] & (disp_q[4*g +: 4] == 4'h0);
    end

    // Digit 0 is never blanked so a zero value still shows a single "0".
    assign lz_blank = blank_lz ? {upper_zero[7:1], 1'b0} : 8'h00;

    assign nib = disp_q[{idx_q, 2'b00} +: 4];

    hex_to_seg7 u_dec (
        .nib_i (nib),
        .seg_o (seg)
    );

    always_comb begin
        presc_d = tick ? '0 : presc_q + CNT_W'(1);
        idx_d   = tick ? idx_q + 3'd1 : idx_q;
        disp_d  = ld ? d_in : disp_q;
        dark    = ~digit_en[idx_q] | lz_blank[idx_q];
        an_d    = dark ? AN_OFF : ~(8'b1 << idx_q);
        hex_d   = dark ? SEG_OFF : seg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q <= '0;
            idx_q   <= '0;
            disp_q  <= '0;
            an_q    <= AN_OFF;
            hex_q   <= SEG_OFF;
        end else begin
            presc_q <= presc_d;
            idx_q   <= idx_d;
            disp_q  <= disp_d;
            an_q    <= an_d;
            hex_q   <= hex_d;
        end
    end

    assign an      = an_q;
    assign hex_out = hex_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// tb_seg7_display_ctrl: self-checking bench for seg7_display_ctrl with a 4-cycle slot.
module tb_seg7_display_ctrl;

    localparam int RC = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld = 1'b0;
    logic [31:0] d_in = '0;
    logic [7:0]  digit_en = 8'hFF;
    logic        blank_lz = 1'b0;
    logic [7:0]  an;
    logic [6:0]  hex_out;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_disp = '0;
    int          m_k = 0;
    logic [7:0]  m_an = 8'hFF;
    logic [6:0]  m_hex = 7'h7F;

    logic [6:0] seg_ref [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    typedef struct {
        logic [31:0] d;
        logic [7:0]  en;
        logic        blz;
        int          slot;
        logic [7:0]  an;
        logic [6:0]  hex;
    } vec_t;

    vec_t vecs [0:16];

    seg7_display_ctrl #(.REFRESH_CNT(RC), .CNT_W(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .ld       (ld),
        .d_in     (d_in),
        .digit_en (digit_en),
        .blank_lz (blank_lz),
        .an       (an),
        .hex_out  (hex_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
        end
    endtask

    // Displayed digit for slot i of value v, from the display rules directly.
    function automatic void ref_out(input int i, input logic [31:0] v, input logic [7:0] en,
                                    input logic blz, output logic [7:0] a, output logic [6:0] h);
        logic [3:0] nv;
        logic       dk;
        nv = 4'(v >> (4 * i));
        dk = !en[i] || (blz && i > 0 && (v >> (4 * i)) == 32'd0);
        a  = dk ? 8'hFF : ~(8'd1 << i);
        h  = dk ? 7'h7F : seg_ref[nv];
    endfunction

    // One clock: drive inputs, advance the model across the edge, compare after the edge.
    task automatic cyc(input logic r, input logic l, input logic [31:0] d);
        rst  = r;
        ld   = l;
        d_in = d;
        @(posedge clk);
        if (r) begin
            m_disp = '0;
            m_k    = 0;
            m_an   = 8'hFF;
            m_hex  = 7'h7F;
        end else begin
            ref_out((m_k / RC) % 8, m_disp, digit_en, blank_lz, m_an, m_hex);
            if (l) m_disp = d;
            m_k++;
        end
        #1;
        chk("model_an", an, m_an);
        chk("model_hex", {1'b0, hex_out}, {1'b0, m_hex});
        chk("an_onehot", 8'($countones(~an) > 1), 8'd0);
    endtask

    initial begin
        vecs[0]  = '{32'h89ABCDEF, 8'hFF, 1'b0, 0, 8'hFE, 7'h0E};
        vecs[1]  = '{32'h89ABCDEF, 8'hFF, 1'b0, 1, 8'hFD, 7'h06};
        vecs[2]  = '{32'h89ABCDEF, 8'hFF, 1'b0, 2, 8'hFB, 7'h21};
        vecs[3]  = '{32'h89ABCDEF, 8'hFF, 1'b0, 3, 8'hF7, 7'h46};
        vecs[4]  = '{32'h89ABCDEF, 8'hFF, 1'b0, 4, 8'hEF, 7'h03};
        vecs[5]  = '{32'h89ABCDEF, 8'hFF, 1'b0, 5, 8'hDF, 7'h08};
        vecs[6]  = '{32'h89ABCDEF, 8'hFF, 1'b0, 6, 8'hBF, 7'h10};
        vecs[7]  = '{32'h89ABCDEF, 8'hFF, 1'b0, 7, 8'h7F, 7'h00};
        vecs[8]  = '{32'h00000305, 8'hFF, 1'b1, 0, 8'hFE, 7'h12};
        vecs[9]  = '{32'h00000305, 8'hFF, 1'b1, 1, 8'hFD, 7'h40};
        vecs[10] = '{32'h00000305, 8'hFF, 1'b1, 2, 8'hFB, 7'h30};
        vecs[11] = '{32'h00000305, 8'hFF, 1'b1, 3, 8'hFF, 7'h7F};
        vecs[12] = '{32'h00000305, 8'hFF, 1'b1, 7, 8'hFF, 7'h7F};
        vecs[13] = '{32'h00000000, 8'hFF, 1'b1, 0, 8'hFE, 7'h40};
        vecs[14] = '{32'h00000000, 8'hFF, 1'b1, 1, 8'hFF, 7'h7F};
        vecs[15] = '{32'h11111111, 8'hFE, 1'b0, 0, 8'hFF, 7'h7F};
        vecs[16] = '{32'h11111111, 8'hFE, 1'b0, 5, 8'hDF, 7'h79};

        // Reset behaviour and free-running scan with an empty display.
        cyc(1'b1, 1'b1, 32'hFFFFFFFF);
        cyc(1'b1, 1'b0, 32'h0);
        chk("rst_an", an, 8'hFF);
        chk("rst_hex", {1'b0, hex_out}, 8'h7F);
        for (int j = 1; j <= 33; j++) begin
            cyc(1'b0, 1'b0, 32'h0);
            if (j == 1)  chk("first_an", an, 8'hFE);
            if (j == 1)  chk("first_hex", {1'b0, hex_out}, 8'h40);
            if (j == 5)  chk("step_an", an, 8'hFD);
            if (j == 29) chk("last_slot_an", an, 8'h7F);
            if (j == 33) chk("wrap_an", an, 8'hFE);
        end

        // Table of per-slot expectations after a fresh reset and load.
        for (int v = 0; v <= 16; v++) begin
            digit_en = vecs[v].en;
            blank_lz = vecs[v].blz;
            cyc(1'b1, 1'b0, 32'h0);
            cyc(1'b0, 1'b1, vecs[v].d);
            repeat (RC * vecs[v].slot + 1) cyc(1'b0, 1'b0, 32'h0);
            chk($sformatf("vec%0d_an", v), an, vecs[v].an);
            chk($sformatf("vec%0d_hex", v), {1'b0, hex_out}, {1'b0, vecs[v].hex});
        end

        // Load in the middle of slot 0.
        digit_en = 8'hFF;
        blank_lz = 1'b0;
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h00000007);
        chk("midld_old_hex", {1'b0, hex_out}, 8'h40);
        cyc(1'b0, 1'b0, 32'h0);
        chk("midld_new_hex", {1'b0, hex_out}, 8'h78);
        chk("midld_an", an, 8'hFE);
        cyc(1'b0, 1'b0, 32'h0);
        chk("midld_hold_hex", {1'b0, hex_out}, 8'h78);
        cyc(1'b0, 1'b0, 32'h0);
        chk("midld_slot_end_an", an, 8'hFD);

        // Reset during slot 5, with a load on the same edge that must be ignored.
        cyc(1'b1, 1'b0, 32'h0);
        cyc(1'b0, 1'b1, 32'h12345678);
        repeat (20) cyc(1'b0, 1'b0, 32'h0);
        chk("pre_rst_an", an, 8'hDF);
        cyc(1'b1, 1'b1, 32'hFFFFFFFF);
        chk("midrst_an", an, 8'hFF);
        chk("midrst_hex", {1'b0, hex_out}, 8'h7F);
        for (int j = 1; j <= 5; j++) begin
            cyc(1'b0, 1'b0, 32'h0);
            chk($sformatf("post_rst%0d_hex", j), {1'b0, hex_out}, 8'h40);
            chk($sformatf("post_rst%0d_an", j), an, j < 5 ? 8'hFE : 8'hFD);
        end

        // Random traffic against the reference model.
        for (int n = 0; n < 3000; n++) begin
            digit_en = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'hFF;
            blank_lz = 1'($urandom_range(0, 1));
            cyc($urandom_range(0, 99) == 0, $urandom_range(0, 7) == 0,
                $urandom >> (4 * $urandom_range(0, 8)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
